// File: rtl/risc_core_hs.sv
// risc_core_hs: parametrised multicycle accumulator CPU with a req/ack
// memory port (any number of wait states) and halt/resume control.
//
// state  | meaning
// BOOT   | one idle cycle after reset release
// FETCH  | read instruction at PC, wait for ack
// DECODE | dispatch on opcode, resolve HLT/SKZ/JMP
// OPRD   | read operand address, apply ALU op on ack
// OPWR   | write accumulator to operand address
// HALTED | idle until run
module risc_core_hs #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              run,
  output logic              halted,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              zero
);

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_OPRD, S_OPWR, S_HALTED
  } state_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc, pc_nxt;
  logic [DATA_W-1:0]   acc, acc_nxt;
  logic [DATA_W-1:0]   ir, ir_nxt;
  logic [2:0]          opcode;
  logic [ADDR_W-1:0]   operand;
  logic                unused_ir;

  assign opcode    = ir[DATA_W-1 -: 3];
  assign operand   = ir[ADDR_W-1:0];
  // Bits between the opcode and operand fields carry no meaning.
  assign unused_ir = ^ir;

  assign mem_wdata = acc;
  assign acc_out   = acc;
  assign pc_out    = pc;
  assign zero      = (acc == '0);
  assign halted    = (state == S_HALTED);

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_BOOT;
      pc    <= RESET_PC;
      acc   <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      acc   <= acc_nxt;
      ir    <= ir_nxt;
    end
  end

  // Next-state, datapath updates and memory port decode.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    acc_nxt   = acc;
    ir_nxt    = ir;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc;
    case (state)
      S_BOOT: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_nxt    = mem_rdata;
          pc_nxt    = pc + PC_ONE;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_HLT: state_nxt = S_HALTED;
          OP_SKZ: begin
            if (zero) pc_nxt = pc + PC_ONE;
            state_nxt = S_FETCH;
          end
          OP_JMP: begin
            pc_nxt    = operand;
            state_nxt = S_FETCH;
          end
          OP_STO:  state_nxt = S_OPWR;
          default: state_nxt = S_OPRD;
        endcase
      end
      S_OPRD: begin
        mem_req  = 1'b1;
        mem_addr = operand;
        if (mem_ack) begin
          case (opcode)
            OP_ADD:  acc_nxt = acc + mem_rdata;
            OP_AND:  acc_nxt = acc & mem_rdata;
            OP_XOR:  acc_nxt = acc ^ mem_rdata;
            default: acc_nxt = mem_rdata;
          endcase
          state_nxt = S_FETCH;
        end
      end
      S_OPWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = operand;
        if (mem_ack) state_nxt = S_FETCH;
      end
      S_HALTED: begin
        if (run) state_nxt = S_FETCH;
      end
      default: state_nxt = S_BOOT;
    endcase
  end

endmodule

// File: tb/tb_risc_core_hs.sv
// Directed bench for risc_core_hs: an 8/5 core with a wait-state memory
// model and a 16/8 core with a zero-wait memory, sharing clock and reset.
module tb_risc_core_hs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;

  logic       mem_req, mem_we, mem_ack, halted, zero;
  logic [4:0] mem_addr, pc_out;
  logic [7:0] mem_wdata, mem_rdata, acc_out;

  logic        req16, we16, ack16, halted16, zero16;
  logic [7:0]  addr16, pc16;
  logic [15:0] wdata16, rdata16, acc16;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  risc_core_hs u_dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .run(run), .halted(halted), .acc_out(acc_out),
    .pc_out(pc_out), .zero(zero)
  );

  risc_core_hs #(.DATA_W(16), .ADDR_W(8)) u_dut16 (
    .clk(clk), .rst(rst), .mem_req(req16), .mem_we(we16),
    .mem_addr(addr16), .mem_wdata(wdata16), .mem_rdata(rdata16),
    .mem_ack(ack16), .run(1'b0), .halted(halted16), .acc_out(acc16),
    .pc_out(pc16), .zero(zero16)
  );

  // ---------------- memory model, 8/5 core ----------------
  logic [7:0] rom [0:31];
  int         n_wait = 0;
  int         cnt;
  int         wr_total = 0;
  logic [4:0] last_wr_addr;
  logic [7:0] last_wr_data;
  int         stab_err, xfer_n, log_n;
  logic [4:0] log_a [0:63];
  logic [4:0] cap_addr;
  logic       cap_we;
  logic [7:0] cap_wdata;

  assign mem_ack   = mem_req && (cnt == n_wait);
  assign mem_rdata = rom[mem_addr];

  // Wait-state counter, transfer log and request stability monitor.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 0; stab_err <= 0; xfer_n <= 0; log_n <= 0;
    end else if (mem_req) begin
      if (cnt == 0) begin
        cap_addr <= mem_addr; cap_we <= mem_we; cap_wdata <= mem_wdata;
      end else if (mem_addr !== cap_addr || mem_we !== cap_we || mem_wdata !== cap_wdata) begin
        stab_err <= stab_err + 1;
      end
      if (mem_ack) begin
        cnt    <= 0;
        xfer_n <= xfer_n + 1;
        if (log_n < 64) log_a[log_n] <= mem_addr;
        log_n  <= log_n + 1;
        if (mem_we) begin
          wr_total     <= wr_total + 1;
          last_wr_addr <= mem_addr;
          last_wr_data <= mem_wdata;
        end
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  // ---------------- memory model, 16/8 core ----------------
  logic [15:0] rom16 [0:255];
  logic [7:0]  w16_addr;
  logic [15:0] w16_data;

  assign ack16   = req16;
  assign rdata16 = rom16[addr16];

  // Capture writes from the wide core.
  always @(posedge clk) begin
    if (req16 && ack16 && we16) begin
      w16_addr <= addr16;
      w16_data <= wdata16;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
  endtask

  // LDA 10, ADD 11, STO 12, HLT
  task automatic load_prog1();
    clear_rom();
    rom[0] = 8'hAA; rom[1] = 8'h4B; rom[2] = 8'hCC; rom[3] = 8'h00;
    rom[10] = 8'h05; rom[11] = 8'h0A;
  endtask

  // SKZ taken/not taken, add wrap, XOR to zero, JMP 31 then wrap to 0
  task automatic load_prog2();
    clear_rom();
    rom[0]  = 8'hB4; rom[1] = 8'h94; rom[2] = 8'h94; rom[3] = 8'h20;
    rom[4]  = 8'h00; rom[5] = 8'h55; rom[6] = 8'h20; rom[7] = 8'hB6;
    rom[8]  = 8'h57; rom[9] = 8'h00; rom[10] = 8'h95; rom[11] = 8'h00;
    rom[12] = 8'hFF; rom[31] = 8'hB6;
    rom[20] = 8'h00; rom[21] = 8'h01; rom[22] = 8'hFF; rom[23] = 8'h02;
  endtask

  // Counts falling edges from now until halted rises, bounded.
  task automatic wait_halt(input int start, output int cyc);
    cyc = start;
    while (!halted && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pulse_run();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  initial begin
    int cyc;
    int wr_before;
    int guard;

    for (int i = 0; i < 256; i++) rom16[i] = 16'h0000;
    rom16[0] = 16'hBF80;  // LDA 0x80 with junk in the gap bits
    rom16[1] = 16'h4081;  // ADD 0x81
    rom16[2] = 16'hC082;  // STO 0x82
    rom16[3] = 16'h0000;  // HLT
    rom16[8'h80] = 16'hFFF0;
    rom16[8'h81] = 16'h0123;

    // ---- reset values and zero-wait program ----
    load_prog1();
    repeat (3) @(negedge clk);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_halted", halted, 0);
    check("rst_acc", acc_out, 0);
    check("rst_pc", pc_out, 0);
    check("rst_zero", zero, 1);
    rst = 1'b0;
    check("boot_req", mem_req, 0);
    @(negedge clk);
    check("fetch0_req", mem_req, 1);
    check("fetch0_we", mem_we, 0);
    check("fetch0_addr", mem_addr, 0);
    wait_halt(1, cyc);
    check("p1_cycles", cyc, 12);
    check("p1_wr_cnt", wr_total, 1);
    check("p1_wr_addr", last_wr_addr, 12);
    check("p1_wr_data", last_wr_data, 8'h0F);
    check("p1_pc", pc_out, 4);
    check("p1_acc", acc_out, 8'h0F);
    check("p1_zero", zero, 0);
    check("w16_halted", halted16, 1);
    check("w16_pc", pc16, 4);
    check("w16_acc", acc16, 16'h0113);
    check("w16_wr_addr", w16_addr, 8'h82);
    check("w16_wr_data", w16_data, 16'h0113);
    repeat (3) @(negedge clk);
    check("p1_hold_halted", halted, 1);
    check("p1_hold_pc", pc_out, 4);
    check("p1_hold_req", mem_req, 0);

    // ---- SKZ, wraparound arithmetic, resume, JMP 31 ----
    rst = 1'b1;
    load_prog2();
    @(negedge clk);
    rst = 1'b0;
    wait_halt(0, cyc);
    check("p2a_halted", halted, 1);
    check("p2a_pc", pc_out, 10);
    check("p2a_acc", acc_out, 8'h01);
    check("p2a_zero", zero, 0);
    check("p2a_log_n", log_n, 15);
    check("skz_taken_fetch", log_a[7], 5);
    check("skz_not_taken_fetch", log_a[10], 7);
    pulse_run();
    check("resume_req", mem_req, 1);
    check("resume_addr", mem_addr, 10);
    check("resume_halted", halted, 0);
    wait_halt(0, cyc);
    check("p2b_pc", pc_out, 12);
    check("p2b_acc", acc_out, 8'h00);
    check("p2b_zero", zero, 1);
    pulse_run();
    wait_halt(0, cyc);
    check("jmp_target", log_a[19], 31);
    check("wrap_fetch", log_a[21], 0);
    check("p2c_pc", pc_out, 10);
    check("p2c_acc", acc_out, 8'h01);

    // ---- three wait states ----
    rst = 1'b1;
    load_prog1();
    n_wait = 3;
    @(negedge clk);
    rst = 1'b0;
    wait_halt(0, cyc);
    check("ws3_cycles", cyc, 33);
    check("ws3_stable", stab_err, 0);
    check("ws3_xfers", xfer_n, 7);
    check("ws3_wr_addr", last_wr_addr, 12);
    check("ws3_wr_data", last_wr_data, 8'h0F);
    check("ws3_pc", pc_out, 4);
    check("ws3_acc", acc_out, 8'h0F);

    // ---- reset during a pending write ----
    rst = 1'b1;
    n_wait = 50;
    @(negedge clk);
    rst = 1'b0;
    guard = 0;
    while (!(mem_req && mem_we) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("opwr_reached", mem_req && mem_we, 1);
    repeat (2) @(negedge clk);
    wr_before = wr_total;
    rst = 1'b1;
    #1;
    check("rst_async_req", mem_req, 0);
    check("rst_async_we", mem_we, 0);
    @(negedge clk);
    @(negedge clk);
    check("rst_no_write", wr_total, wr_before);
    n_wait = 0;
    rst = 1'b0;
    check("restart_pc", pc_out, 0);
    wait_halt(0, cyc);
    check("restart_cycles", cyc, 12);
    check("restart_wr_cnt", wr_total, wr_before + 1);
    check("restart_wr_data", last_wr_data, 8'h0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_core_hs.md
# risc_core_hs

Parametrised multicycle accumulator CPU and successor to the fixed 8-bit `risc_cpu`. Data width, address width and reset vector are configurable. The built-in memory and fixed-phase controller are replaced by an external req/ack memory port that tolerates any number of wait states. The block adds halt/resume control and status outputs, and instantiates as the CPU top inside SoC wrappers that supply memory.

## Interface
Parameters:
- `DATA_W`, 8, accumulator and instruction word width; must satisfy `DATA_W >= ADDR_W+3`.
- `ADDR_W`, 5, memory address width; PC width.
- `RESET_PC`, 0, PC value after reset.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_req`  out  1  memory transfer request; decoded combinationally from FSM state.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`=1.
- `mem_addr`  out  `ADDR_W`  transfer address.
- `mem_wdata`  out  `DATA_W`  write data; equals accumulator.
- `mem_rdata`  in  `DATA_W`  read data; sampled only on an ack edge.
- `mem_ack`  in  1  transfer complete; ignored while `mem_req`=0.
- `run`  in  1  resume request; sampled only in HALTED.
- `halted`  out  1  1 while in HALTED.
- `acc_out`  out  `DATA_W`  accumulator.
- `pc_out`  out  `ADDR_W`  program counter.
- `zero`  out  1  `acc_out == 0`; combinational.

## Operation
- Instruction fields: opcode = `instr[DATA_W-1:DATA_W-3]`; operand = `instr[ADDR_W-1:0]`; other bits ignored.
- Opcodes: HLT 000, SKZ 001, ADD 010, AND 011, XOR 100, LDA 101, STO 110, JMP 111.
- FSM states: BOOT, FETCH, DECODE, OPRD, OPWR, HALTED.
- BOOT: `mem_req`=0; unconditionally goes to FETCH.
- FETCH: `mem_req`=1, `mem_we`=0, `mem_addr`=PC. On ack: IR <= `mem_rdata`, PC <= PC+1, go to DECODE.
- DECODE: `mem_req`=0.
  - HLT goes to HALTED.
  - SKZ: if `zero`, PC <= PC+1. Go to FETCH.
  - JMP: PC <= operand. Go to FETCH.
  - ADD, AND, XOR, LDA go to OPRD.
  - STO goes to OPWR.
- OPRD: read at operand address. On ack, ACC <= ADD: ACC+rdata; AND: ACC&rdata; XOR: ACC^rdata; LDA: rdata. Then go to FETCH.
- OPWR: `mem_we`=1, `mem_addr`=operand, `mem_wdata`=ACC. On ack, go to FETCH.
- HALTED: `mem_req`=0, PC and ACC held. `run`=1 on a rising edge moves to FETCH.
- Arithmetic is modulo 2^`DATA_W`; carry discarded.
- PC arithmetic is modulo 2^`ADDR_W`. PC = max+1 wraps to 0, and an SKZ skip may wrap.

## Timing
- Reset values: `mem_req`=0, `mem_we`=0, `mem_addr`=`RESET_PC`, `mem_wdata`=0, `halted`=0, `acc_out`=0, `pc_out`=`RESET_PC`, `zero`=1. IR=0; state=BOOT.
- Reset applies asynchronously at any time, including mid-transfer. `mem_req` drops immediately and the pending transfer is abandoned; a late ack is ignored.
- Handshake:
  - `mem_addr`, `mem_we` and `mem_wdata` are stable from the first cycle of a request until the edge where `mem_ack` is sampled high.
  - `mem_ack` may be high in the first request cycle, giving zero wait states.
  - `mem_req` deasserts, or re-addresses at the next FETCH, in the cycle after the ack edge.
- Minimum cycles per instruction with zero-wait memory: JMP, SKZ, HLT 2; ADD, AND, XOR, LDA, STO 3. Each wait state adds 1.
- After reset release: 1 BOOT cycle, then FETCH of `RESET_PC`.
- `run` held high during the DECODE of HLT has no effect; HALTED still lasts at least 1 cycle.
- `run` outside HALTED is ignored.

## Test plan
- Reset behaviour → during reset all outputs hold reset values. The first post-release cycle has `mem_req`=0. The second has `mem_req`=1, `mem_we`=0, `mem_addr`=0.
- Zero-wait program LDA 10, ADD 11, STO 12, HLT, with mem[10]=0x05 and mem[11]=0x0A:
  - write of 0x0F to address 12;
  - `halted`=1 exactly 12 cycles after reset release;
  - `pc_out`=4, `acc_out`=0x0F.
- SKZ with ACC=0 at address 3 → next fetch address 5. SKZ with ACC=0x01 → next fetch address 4.
- ACC=0xFF, ADD of 0x02 → ACC=0x01, `zero`=0. XOR with 0x01 → ACC=0, `zero`=1. JMP 31 then a non-jump at 31 → next fetch address 0.
- 3-wait-state memory running the LDA/ADD/STO/HLT program:
  - `mem_req`, `mem_addr`, `mem_we`, `mem_wdata` are stable for 4 cycles per transfer;
  - final state matches the zero-wait run;
  - total is 12 + 3×7 = 33 cycles.
- Halt, resume and reset:
  - `run` pulse while halted → fetch of the address after HLT.
  - `rst` asserted mid-OPWR with ack pending → `mem_req` low immediately, memory unchanged.
  - After release, execution restarts at `RESET_PC`.
  - Run once with `DATA_W`=16, `ADDR_W`=8.
